// File: rtl/nios2_qsys_cpu_oci_dct_packer.sv
// DCT trace writer: packs 2-bit trace atoms into a 30-bit buffer and commits 32-bit words.
// Optional macro NIOS2_QSYS_CPU_OCI_DCT_STATS_EN adds a saturating words_emitted counter.
module nios2_qsys_cpu_oci_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom_data,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        test_ending,
    input  logic        test_has_ended,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        word_valid,
    output logic [31:0] word_data,
    input  logic        word_ready,
`ifdef NIOS2_QSYS_CPU_OCI_DCT_STATS_EN
    output logic [15:0] words_emitted,
`endif
    output logic [1:0]  state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // word_valid/word_data hold steady until word_ready, atom_valid may be withdrawn freely.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q;
    logic        flush_pending;
    logic        test_ending_q;
    logic        slot_free;
    logic        flush_req;
    logic        store;
    logic        commit;
    logic [1:0]  marker;
    logic [29:0] next_buf;
    logic [3:0]  next_cnt;
    logic        next_pending;

    assign state      = state_q;
    assign slot_free  = !word_valid || word_ready;
    assign flush_req  = flush || (test_ending && !test_ending_q);
    assign atom_ready = !test_has_ended && !flush_pending &&
                        ((dct_count != 4'd15) || slot_free);
    assign store      = atom_valid && atom_ready && (atom_data != 2'b00);
    assign commit     = slot_free && ((dct_count == 4'd15) || flush_pending);
    assign marker     = (dct_count == 4'd15) ? 2'b11 : 2'b01;

    // Commit empties the buffer first, so an atom on the same edge lands in slot 0.
    always_comb begin
        next_buf = commit ? 30'd0 : dct_buffer;
        next_cnt = commit ? 4'd0 : dct_count;
        if (store) begin
            next_buf[{next_cnt, 1'b0} +: 2] = atom_data;
            next_cnt = next_cnt + 4'd1;
        end
        // Only arm a flush when something will actually be left to send.
        next_pending = flush_pending && !commit;
        if (flush_req && (next_cnt != 4'd0)) begin
            next_pending = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer    <= 30'd0;
            dct_count     <= 4'd0;
            word_valid    <= 1'b0;
            word_data     <= 32'd0;
            flush_pending <= 1'b0;
            test_ending_q <= 1'b0;
            state_q       <= FILL;
        end else begin
            dct_buffer    <= next_buf;
            dct_count     <= next_cnt;
            flush_pending <= next_pending;
            test_ending_q <= test_ending;
            if (commit) begin
                word_valid <= 1'b1;
                word_data  <= {marker, dct_buffer};
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
            if (next_pending) begin
                state_q <= FLUSH;
            end else if (next_cnt == 4'd15) begin
                state_q <= FULL;
            end else begin
                state_q <= FILL;
            end
        end
    end

`ifdef NIOS2_QSYS_CPU_OCI_DCT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_emitted <= 16'd0;
        end else if (word_valid && word_ready && (words_emitted != 16'hFFFF)) begin
            words_emitted <= words_emitted + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nios2_qsys_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer: scoreboarded output words plus register/handshake checks.
module tb_nios2_qsys_cpu_oci_dct_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'b00;
    logic        atom_ready;
    logic        flush = 1'b0;
    logic        test_ending = 1'b0;
    logic        test_has_ended = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready = 1'b1;
    logic [1:0]  state;
`ifdef NIOS2_QSYS_CPU_OCI_DCT_STATS_EN
    logic [15:0] words_emitted;
`endif

    int          n_checks = 0;
    int          n_pass = 0;
    int          stalls = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    nios2_qsys_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_ready     (word_ready),
`ifdef NIOS2_QSYS_CPU_OCI_DCT_STATS_EN
        .words_emitted  (words_emitted),
`endif
        .state          (state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every completed output handshake must match the head of exp_q.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
            end else begin
                mon_exp = 32'hxxxx_xxxx;
            end
            check("word_out", word_data, mon_exp);
        end
    end

    // Driver tasks: all start and end at 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_atom(input logic [1:0] d);
        int n = 0;
        atom_valid = 1'b1;
        atom_data  = d;
        @(negedge clk);
        if (!atom_ready) stalls++;
        while (!atom_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("atom_accept_timeout", 32'(atom_ready), 32'd1);
        @(posedge clk);
        #1;
        atom_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [1:0] d);
        for (int i = 0; i < n; i++) send_atom(d);
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_buffer", 32'(dct_buffer), 32'd0);
        check("rst_count", 32'(dct_count), 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_data", word_data, 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b0;
        cycles(1);
        check("idle_atom_ready", 32'(atom_ready), 32'd1);

        // 15 atoms of 01 -> one full word
        exp_q.push_back(32'hD555_5555);
        send_n(15, 2'b01);
        check("full_count15", 32'(dct_count), 32'd15);
        check("full_buffer", 32'(dct_buffer), 32'h1555_5555);
        check("full_state", 32'(state), 32'd1);
        cycles(1);
        check("full_count0", 32'(dct_count), 32'd0);
        check("full_word_valid", 32'(word_valid), 32'd1);
        cycles(3);

        // 30 back-to-back atoms of 10 -> two words, no stall at the wrap
        stalls = 0;
        exp_q.push_back(32'hEAAA_AAAA);
        exp_q.push_back(32'hEAAA_AAAA);
        send_n(30, 2'b10);
        check("stream_no_stall", 32'(stalls), 32'd0);
        cycles(3);
        check("stream_count0", 32'(dct_count), 32'd0);

        // Partial flush of 01,10,11
        exp_q.push_back(32'h4000_0039);
        send_atom(2'b01);
        send_atom(2'b10);
        send_atom(2'b11);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check("flush_state", 32'(state), 32'd2);
        check("flush_hold_count", 32'(dct_count), 32'd3);
        check("flush_pending_ready", 32'(atom_ready), 32'd0);
        cycles(1);
        check("flush_count0", 32'(dct_count), 32'd0);
        check("flush_word_valid", 32'(word_valid), 32'd1);
        cycles(2);
        // Empty flush must not produce a word
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(3);
        check("empty_flush_no_word", 32'(word_valid), 32'd0);
        // Atom accepted in the flush cycle is part of the flushed word
        exp_q.push_back(32'h4000_0003);
        flush = 1'b1;
        send_atom(2'b11);
        flush = 1'b0;
        cycles(3);

        // Backpressure: first word held, buffer fills, then released
        word_ready = 1'b0;
        exp_q.push_back(32'hEAAA_AAAA);
        exp_q.push_back(32'hD555_5555);
        send_n(15, 2'b10);
        send_n(15, 2'b01);
        cycles(3);
        check("bp_count15", 32'(dct_count), 32'd15);
        check("bp_atom_ready", 32'(atom_ready), 32'd0);
        check("bp_word_held", word_data, 32'hEAAA_AAAA);
        check("bp_state_full", 32'(state), 32'd1);
        word_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(atom_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_second_word", word_data, 32'hD555_5555);
        check("bp_second_valid", 32'(word_valid), 32'd1);
        check("bp_count_after", 32'(dct_count), 32'd0);
        cycles(3);

        // test_ending rise with 5 atoms held, then test_has_ended
        exp_q.push_back(32'h4000_03FF);
        send_n(5, 2'b11);
        test_ending = 1'b1;
        cycles(1);
        test_has_ended = 1'b1;
        #1;
        check("ended_atom_ready", 32'(atom_ready), 32'd0);
        atom_valid = 1'b1;
        atom_data  = 2'b01;
        cycles(4);
        check("ended_atom_ready_hold", 32'(atom_ready), 32'd0);
        check("ended_count0", 32'(dct_count), 32'd0);
        atom_valid = 1'b0;
        test_has_ended = 1'b0;
        test_ending = 1'b0;
        cycles(2);

        // Asynchronous reset mid-fill with a held word
        word_ready = 1'b0;
        send_n(15, 2'b01);
        send_n(7, 2'b10);
        check("pre_rst_count", 32'(dct_count), 32'd7);
        check("pre_rst_valid", 32'(word_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(dct_count), 32'd0);
        check("async_rst_buffer", 32'(dct_buffer), 32'd0);
        check("async_rst_valid", 32'(word_valid), 32'd0);
        check("async_rst_data", word_data, 32'd0);
        cycles(2);
        reset = 1'b0;
        word_ready = 1'b1;
        cycles(4);
        check("post_rst_no_word", 32'(word_valid), 32'd0);

        check("words_outstanding", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
